// File: rtl/dmem_arb_pkg.sv
// dmem_arbiter shared types: FSM states, requester ids, width defaults.
// Optional round-robin arbitration is enabled by DMEM_ARBITER_RR_EN.
package dmem_arb_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_LDR = 1'b1
  } req_id_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arbiter winner select: a lone request wins, a tie goes to ptr.
// ptr is held at REQ_CPU by the top when DMEM_ARBITER_RR_EN is undefined.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic cpu_req,
  input  logic ldr_req,
  input  logic ptr,
  output logic win
);

  // tie -> pointer, otherwise whoever asks
  always_comb begin
    win = REQ_CPU;
    if (cpu_req && ldr_req) begin
      win = ptr;
    end else if (ldr_req) begin
      win = REQ_LDR;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data memory arbiter (CPU and loader/debug port).
// Define DMEM_ARBITER_RR_EN for round-robin ties; default is CPU-first.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_stall
);

  state_t            state_q;
  state_t            state_d;
  logic              win_q;
  logic              win_d;
  logic              ptr;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] ldr_rdata_q;
  logic              any_req;
  logic              take;
  logic              acc;
  logic              rsp;

  assign any_req = cpu_req | ldr_req;
  assign take    = (state_q == IDLE) & any_req;
  assign acc     = (state_q == ACCESS);
  assign rsp     = (state_q == RESP);

  dmem_arb_pick u_pick (
    .cpu_req (cpu_req),
    .ldr_req (ldr_req),
    .ptr     (ptr),
    .win     (win_d)
  );

`ifdef DMEM_ARBITER_RR_EN
  logic ptr_q;

  // last winner drops to lowest priority for the next tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= REQ_CPU;
    end else if (take) begin
      ptr_q <= ~win_d;
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = REQ_CPU;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: writes skip RESP
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  state_d = we_q ? IDLE : RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // latch the winner's operands at the IDLE sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_q   <= REQ_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (take) begin
      win_q   <= win_d;
      we_q    <= win_d ? ldr_we : cpu_we;
      addr_q  <= win_d ? ldr_addr : cpu_addr;
      wdata_q <= win_d ? ldr_wdata : cpu_wdata;
    end
  end

  // capture read data at the end of ACCESS; held otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else if (acc && !we_q) begin
      if (win_q == REQ_LDR) begin
        ldr_rdata_q <= mem_rdata;
      end else begin
        cpu_rdata_q <= mem_rdata;
      end
    end
  end

  // outputs decoded from state and winner
  always_comb begin
    cpu_gnt    = acc & (win_q == REQ_CPU);
    ldr_gnt    = acc & (win_q == REQ_LDR);
    cpu_rvalid = rsp & (win_q == REQ_CPU);
    ldr_rvalid = rsp & (win_q == REQ_LDR);
    mem_en     = acc;
    mem_we     = acc & we_q;
    mem_addr   = acc ? addr_q : '0;
    mem_wdata  = acc ? wdata_q : '0;
  end

  assign cpu_rdata = cpu_rdata_q;
  assign ldr_rdata = ldr_rdata_q;

  // hold the PC until a write is granted or read data returns
  assign cpu_stall = ~reset & cpu_req
                   & ~(cpu_gnt & cpu_we)
                   & ~cpu_rvalid;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scoreboard bench for dmem_arbiter.
// Grant order and read data are queued at stimulus time, popped on output.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [4:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        ldr_req;
  logic        ldr_we;
  logic [4:0]  ldr_addr;
  logic [31:0] ldr_wdata;
  logic        ldr_gnt;
  logic        ldr_rvalid;
  logic [31:0] ldr_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        cpu_stall;

  logic [31:0] mm [0:31];

  logic [31:0] gnt_q [$];
  logic [31:0] cpu_rd_q [$];
  logic [31:0] ldr_rd_q [$];

  int n_cmp;
  int n_bad;

  assign mem_rdata = mm[mem_addr];

  dmem_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .ldr_req    (ldr_req),
    .ldr_we     (ldr_we),
    .ldr_addr   (ldr_addr),
    .ldr_wdata  (ldr_wdata),
    .ldr_gnt    (ldr_gnt),
    .ldr_rvalid (ldr_rvalid),
    .ldr_rdata  (ldr_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .cpu_stall  (cpu_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_cpu_gnt"}, 32'(cpu_gnt), 0);
    chk({tag, "_ldr_gnt"}, 32'(ldr_gnt), 0);
    chk({tag, "_cpu_rv"}, 32'(cpu_rvalid), 0);
    chk({tag, "_ldr_rv"}, 32'(ldr_rvalid), 0);
    chk({tag, "_mem_en"}, 32'(mem_en), 0);
    chk({tag, "_mem_we"}, 32'(mem_we), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_cpu_rdata"}, cpu_rdata, 0);
    chk({tag, "_ldr_rdata"}, ldr_rdata, 0);
    chk({tag, "_stall"}, 32'(cpu_stall), 0);
  endtask

  // advance one cycle and drain the scoreboard on any output event
  task automatic tick();
    logic [31:0] e;
    @(posedge clk);
    #1;
    if (cpu_gnt || ldr_gnt) begin
      chk("gnt_expected", 32'(gnt_q.size() > 0), 1);
      chk("gnt_onehot", 32'(cpu_gnt & ldr_gnt), 0);
      if (gnt_q.size() > 0) begin
        e = gnt_q.pop_front();
        chk("gnt_id", 32'(ldr_gnt), e);
      end
    end
    if (cpu_rvalid) begin
      chk("cpu_rv_expected", 32'(cpu_rd_q.size() > 0), 1);
      if (cpu_rd_q.size() > 0) begin
        e = cpu_rd_q.pop_front();
        chk("cpu_rdata", cpu_rdata, e);
      end
    end
    if (ldr_rvalid) begin
      chk("ldr_rv_expected", 32'(ldr_rd_q.size() > 0), 1);
      if (ldr_rd_q.size() > 0) begin
        e = ldr_rd_q.pop_front();
        chk("ldr_rdata", ldr_rdata, e);
      end
    end
  endtask

  initial begin
    logic [31:0] w;
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 32; i++) mm[i] = 32'h0;
    mm[0]  = 32'h11110000;
    mm[4]  = 32'hDEADBEEF;
    mm[8]  = 32'hCAFE0008;
    mm[12] = 32'h2222000C;
    mm[16] = 32'hBAD00010;
    reset = 1'b1;
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 5'h00;
    cpu_wdata = 32'h0;
    ldr_req = 1'b0;
    ldr_we = 1'b0;
    ldr_addr = 5'h00;
    ldr_wdata = 32'h0;

    // reset state, stall cleared despite a pending request
    tick();
    tick();
    chk_zero("rst");
    cpu_req = 1'b0;
    reset = 1'b0;
    tick();

    // contention: both read continuously
    cpu_req = 1'b1;
    cpu_addr = 5'h00;
    ldr_req = 1'b1;
    ldr_addr = 5'h0C;
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARBITER_RR_EN
      w = 32'(i % 2);
`else
      w = 0;
`endif
      gnt_q.push_back(w);
      if (w == 0) cpu_rd_q.push_back(32'h11110000);
      else ldr_rd_q.push_back(32'h2222000C);
    end
    for (int i = 0; i < 11; i++) tick();
    cpu_req = 1'b0;
    ldr_req = 1'b0;
    tick();
    chk("cont_gnt_drained", 32'(gnt_q.size()), 0);
    chk("cont_ldr_drained", 32'(ldr_rd_q.size()), 0);

    // CPU read alone at 0x04
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 5'h04;
    gnt_q.push_back(0);
    cpu_rd_q.push_back(32'hDEADBEEF);
    tick();
    chk("rd_gnt_n1", 32'(cpu_gnt), 1);
    chk("rd_mem_en", 32'(mem_en), 1);
    chk("rd_mem_we", 32'(mem_we), 0);
    chk("rd_mem_addr", 32'(mem_addr), 32'h04);
    chk("rd_stall_acc", 32'(cpu_stall), 1);
    tick();
    chk("rd_rvalid_n2", 32'(cpu_rvalid), 1);
    chk("rd_stall_resp", 32'(cpu_stall), 0);
    cpu_req = 1'b0;
    tick();
    chk("rd_rvalid_drop", 32'(cpu_rvalid), 0);
    chk("rd_rdata_hold", cpu_rdata, 32'hDEADBEEF);
    chk("rd_stall_after", 32'(cpu_stall), 0);

    // LDR write alone at 0x1C
    ldr_req = 1'b1;
    ldr_we = 1'b1;
    ldr_addr = 5'h1C;
    ldr_wdata = 32'h12345678;
    gnt_q.push_back(1);
    tick();
    chk("wr_ldr_gnt", 32'(ldr_gnt), 1);
    chk("wr_cpu_gnt", 32'(cpu_gnt), 0);
    chk("wr_mem_en", 32'(mem_en), 1);
    chk("wr_mem_we", 32'(mem_we), 1);
    chk("wr_mem_addr", 32'(mem_addr), 32'h1C);
    chk("wr_mem_wdata", mem_wdata, 32'h12345678);
    ldr_req = 1'b0;
    ldr_we = 1'b0;
    tick();
    chk("wr_idle_en", 32'(mem_en), 0);
    chk("wr_no_rvalid", 32'(ldr_rvalid), 0);

    // operand change after the IDLE sample is ignored
    cpu_req = 1'b1;
    cpu_addr = 5'h08;
    gnt_q.push_back(0);
    cpu_rd_q.push_back(32'hCAFE0008);
    tick();
    cpu_addr = 5'h10;
    #1;
    chk("hold_mem_addr", 32'(mem_addr), 32'h08);
    tick();
    cpu_req = 1'b0;
    tick();

    // reset during RESP aborts the read
    cpu_req = 1'b1;
    cpu_addr = 5'h04;
    gnt_q.push_back(0);
    tick();
    chk("abort_gnt", 32'(cpu_gnt), 1);
    @(posedge clk);
    reset = 1'b1;
    #1;
    chk_zero("abort");
    tick();
    reset = 1'b0;
    cpu_req = 1'b0;
    tick();

    // first tie after reset goes to CPU
    cpu_req = 1'b1;
    cpu_addr = 5'h00;
    ldr_req = 1'b1;
    ldr_addr = 5'h0C;
    gnt_q.push_back(0);
    cpu_rd_q.push_back(32'h11110000);
    tick();
    chk("tie_cpu_gnt", 32'(cpu_gnt), 1);
    chk("tie_ldr_gnt", 32'(ldr_gnt), 0);
    tick();
    cpu_req = 1'b0;
    ldr_req = 1'b0;
    tick();

    chk("end_gnt_q", 32'(gnt_q.size()), 0);
    chk("end_cpu_q", 32'(cpu_rd_q.size()), 0);
    chk("end_ldr_q", 32'(ldr_rd_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, byte address width of the 32-byte data memory.
REQ-002 SHALL have parameter DATA_W, default 32, word width; bytes are stored big-endian, MSB at the lowest address.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports cpu_req/cpu_we  input  1 each  processor access request / write-not-read.
REQ-006 SHALL have ports cpu_addr  input  ADDR_W and cpu_wdata  input  DATA_W.
REQ-007 SHALL have ports cpu_gnt  output  1, cpu_rvalid  output  1, cpu_rdata  output  DATA_W.
REQ-008 SHALL have the same port set for the loader/debug requester, with prefix ldr_ in place of cpu_.
REQ-009 SHALL have ports mem_en/mem_we  output  1 each, mem_addr  output  ADDR_W, mem_wdata  output  DATA_W, mem_rdata  input  DATA_W (memory read is combinational).
REQ-010 SHALL have port cpu_stall  output  1  holds the PC while the processor access is pending.

Function
REQ-011 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-012 IDLE: if any req is high, SHALL select a winner, register its we/addr/wdata and go to ACCESS; otherwise stay in IDLE.
REQ-013 ACCESS: SHALL assert the winner's gnt, mem_en, mem_we=registered we and the registered addr/wdata for exactly one cycle; then go to RESP on a read or IDLE on a write.
REQ-014 RESP: SHALL register mem_rdata captured during ACCESS and present it on the winner's rdata with rvalid high for one cycle; then go to IDLE.
REQ-015 Latency: request sampled in cycle N -> gnt in N+1 -> rvalid in N+2 (reads); minimum inter-grant spacing is 2 cycles for writes and 3 cycles for reads.
REQ-016 Requesters SHALL hold req and operands stable until gnt; the arbiter ignores operand changes after the IDLE sample.
REQ-017 A requester's req being high during ACCESS or RESP SHALL be treated as a new request only after the return to IDLE.
REQ-018 Simultaneous requests SHALL be resolved per REQ-024; a lone request always wins.
REQ-019 cpu_stall SHALL be cpu_req AND NOT (cpu_gnt AND cpu_we) AND NOT cpu_rvalid.
REQ-020 Address SHALL be passed unmodified; modulo-32 byte wrap of addr..addr+3 is the memory's responsibility.
REQ-021 rdata SHALL hold its last value when rvalid is low; the non-winner's gnt/rvalid SHALL stay low.

Reset
REQ-022 On reset, SHALL force IDLE, clear all gnt/rvalid/mem_en/mem_we/cpu_stall, clear all rdata, mem_addr and mem_wdata to 0, and set the priority pointer to CPU.
REQ-023 Reset during ACCESS or RESP SHALL abort the transaction with no rvalid issued; a write already presented in ACCESS may have completed.

Configuration
REQ-024 Macro DMEM_ARBITER_RR_EN defined: round-robin arbitration; the last winner gets lowest priority on the next tie. Macro undefined: fixed priority, CPU always wins ties, and the pointer register is removed.

Structure
REQ-025 Package dmem_arb_pkg SHALL hold the FSM state enum, the requester-id type (REQ_CPU, REQ_LDR) and the ADDR_W/DATA_W defaults.
REQ-026 Winner selection SHALL be the sub-module dmem_arb_pick, which takes both req bits and the pointer and returns the winner id.

Verification
REQ-027 CPU read alone, addr=5'h04, mem_rdata=32'hDEADBEEF -> cpu_gnt in cycle N+1, cpu_rvalid with cpu_rdata=32'hDEADBEEF in cycle N+2, cpu_stall low afterward.
REQ-028 LDR write alone, addr=5'h1C, wdata=32'h12345678 -> mem_en=mem_we=1, mem_addr=5'h1C, mem_wdata=32'h12345678 in ACCESS, no rvalid, FSM back in IDLE the next cycle.
REQ-029 Both requesters read continuously with RR enabled -> grants alternate CPU, LDR, CPU, ...; with RR disabled -> CPU is granted every time while LDR starves.
REQ-030 Reset asserted during RESP of a CPU read -> no cpu_rvalid, all outputs 0 in the same cycle, next tie after reset won by CPU.
REQ-031 cpu_addr changed from 5'h08 to 5'h10 after sampling -> mem_addr=5'h08 in ACCESS.
